// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared states, default geometry and read-latency bounds for the hash stream loader
package hash_pkg;
  localparam int HASH_COEF_W      = 13;
  localparam int HASH_MAX_DEG     = 624;
  localparam int HASH_ADDR_W      = 11;
  localparam int HASH_RD_LAT_MIN  = 1;
  localparam int HASH_RD_LAT_MAX  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } hash_state_e;
endpackage

// File: rtl/hash_rd_pipe.sv
// rtl/hash_rd_pipe.sv - RD_LAT-deep valid delay line tagging returning memory read data
module hash_rd_pipe
  import hash_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid,
  output logic pending
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;

  generate
    if (RD_LAT < HASH_RD_LAT_MIN || RD_LAT > HASH_RD_LAT_MAX) begin : g_bad_lat
      $error("hash_rd_pipe: RD_LAT out of range");
    end
    // pending excludes the output stage: that word is being captured this cycle
    if (RD_LAT == 1) begin : g_single
      always_comb begin
        vld_d   = in_valid;
        pending = in_valid;
      end
    end else begin : g_multi
      always_comb begin
        vld_d   = {vld_q[RD_LAT-2:0], in_valid};
        pending = in_valid | (|vld_q[RD_LAT-2:0]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];

endmodule

// File: rtl/hash_stream_loader.sv
// rtl/hash_stream_loader.sv - streams n coefficients from memory into a packed buffer
// HASH_LSB_FIRST_EN: place coefficient k in place at [k*COEF_W +: COEF_W] instead of shifting left
module hash_stream_loader
  import hash_pkg::*;
#(
  parameter int COEF_W  = HASH_COEF_W,
  parameter int MAX_DEG = HASH_MAX_DEG,
  parameter int ADDR_W  = HASH_ADDR_W,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         degp,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [COEF_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic [COEF_W*MAX_DEG-1:0] hash_data,
  output logic [ADDR_W-1:0]         count,
  output logic                      deg_err
);

  localparam int                HASH_W     = COEF_W * MAX_DEG;
  localparam logic [ADDR_W-1:0] MAX_N      = ADDR_W'(MAX_DEG);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

  hash_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                deg_err_q, deg_err_d;
  logic [2:0]          drain_q, drain_d;
  logic                cap_valid;
  logic                pending;

  hash_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_en_q),
    .out_valid (cap_valid),
    .pending   (pending)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    rd_en_d   = rd_en_q;
    count_d   = count_q;
    hash_d    = hash_q;
    deg_err_d = deg_err_q;
    drain_d   = drain_q;

    if (cap_valid) begin
      count_d = count_q + 1'b1;
`ifdef HASH_LSB_FIRST_EN
      for (int k = 0; k < MAX_DEG; k++) begin
        if (count_q == ADDR_W'(k)) begin
          hash_d[k*COEF_W +: COEF_W] = mem_rdata;
        end
      end
`else
      hash_d = {hash_q[HASH_W-COEF_W-1:0], mem_rdata};
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          deg_err_d = deg_err_q | (degp > MAX_N);
          n_d       = (degp > MAX_N) ? MAX_N : degp;
          hash_d    = '0;
          count_d   = '0;
          drain_d   = '0;
          if (n_d == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
            rd_en_d = 1'b1;
            addr_d  = '0;
          end
        end
      end
      S_ISSUE: begin
        if (addr_q == n_q - 1'b1) begin
          rd_en_d = 1'b0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // fixed RD_LAT-cycle drain keeps latency uniform, including the n=0 case
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST && !pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      count_q   <= '0;
      hash_q    <= '0;
      deg_err_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      count_q   <= count_d;
      hash_q    <= hash_d;
      deg_err_q <= deg_err_d;
      drain_q   <= drain_d;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign hash_data = hash_q;
  assign count     = count_q;
  assign deg_err   = deg_err_q;

endmodule

// File: tb/tb_hash_stream_loader.sv
// tb/tb_hash_stream_loader.sv - self-checking bench: RD_LAT=1 and RD_LAT=3 loaders against a cycle-level model
module tb_hash_stream_loader;

  localparam int HW = 13 * 624;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_s [2];
  logic [10:0]       degp_s  [2];
  logic              rd_w    [2];
  logic [10:0]       addr_w  [2];
  logic [12:0]       rdata_w [2];
  logic              busy_w  [2];
  logic              done_w  [2];
  logic              derr_w  [2];
  logic [10:0]       count_w [2];
  logic [HW-1:0]     hash_w  [2];

  logic [12:0]       mem [0:2047];
  logic              pv  [2][4];
  logic [10:0]       pa  [2][4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hash_stream_loader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .degp(degp_s[0]),
    .mem_rd_en(rd_w[0]), .mem_addr(addr_w[0]), .mem_rdata(rdata_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .hash_data(hash_w[0]),
    .count(count_w[0]), .deg_err(derr_w[0])
  );

  hash_stream_loader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .degp(degp_s[1]),
    .mem_rd_en(rd_w[1]), .mem_addr(addr_w[1]), .mem_rdata(rdata_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .hash_data(hash_w[1]),
    .count(count_w[1]), .deg_err(derr_w[1])
  );

  // memory with per-instance read latency; junk on the bus when no read is returning
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pv[i][0] <= rd_w[i];
      pa[i][0] <= addr_w[i];
      for (int s = 1; s < 4; s++) begin
        pv[i][s] <= pv[i][s-1];
        pa[i][s] <= pa[i][s-1];
      end
    end
  end
  assign rdata_w[0] = pv[0][0] ? mem[pa[0][0]] : 13'h1555;
  assign rdata_w[1] = pv[1][2] ? mem[pa[1][2]] : 13'h1555;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: low64 got %0h want %0h (t=%0t)", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  // model: a load of n words accepted at edge 0 puts read k-1 on the bus in cycle k (k<=n),
  // has L+min(...) captured words visible by formula, and pulses done in cycle n+L+1
  int            m_act   [2];
  int            m_k     [2];
  int            m_n     [2];
  int            m_cnt   [2];
  int            m_last  [2];
  bit            m_derr  [2];
  logic [HW-1:0] m_hash  [2];
  int            m_lat   [2] = '{1, 3};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_n[i] = 0; m_cnt[i] = 0;
      m_last[i] = 0; m_derr[i] = 0; m_hash[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int e_rd, e_addr, e_busy, e_done, c;
        if (!rst_n) begin
          m_act[i] = 0; m_cnt[i] = 0; m_last[i] = 0; m_derr[i] = 0; m_hash[i] = '0;
        end
        if (m_act[i] != 0) begin
          e_rd   = (m_k[i] <= m_n[i]) ? 1 : 0;
          e_addr = (m_k[i] <= m_n[i]) ? m_k[i] - 1 : m_last[i];
          e_busy = 1;
          e_done = (m_k[i] == m_n[i] + m_lat[i] + 1) ? 1 : 0;
        end else begin
          e_rd = 0; e_addr = m_last[i]; e_busy = 0; e_done = 0;
        end
        chk($sformatf("rd_en[%0d]", i), 64'(rd_w[i]), 64'(e_rd));
        if (e_rd != 0 || m_act[i] == 0)
          chk($sformatf("addr[%0d]", i), 64'(addr_w[i]), 64'(e_addr));
        chk($sformatf("busy[%0d]", i), 64'(busy_w[i]), 64'(e_busy));
        chk($sformatf("done[%0d]", i), 64'(done_w[i]), 64'(e_done));
        chk($sformatf("count[%0d]", i), 64'(count_w[i]), 64'(m_cnt[i]));
        chk($sformatf("deg_err[%0d]", i), 64'(derr_w[i]), 64'(m_derr[i]));
        chk_w($sformatf("hash[%0d]", i), hash_w[i], m_hash[i]);

        if (rst_n) begin
          if (m_act[i] != 0) begin
            if (m_k[i] <= m_n[i]) m_last[i] = m_k[i] - 1;
            m_k[i]++;
            if (m_k[i] > m_n[i] + m_lat[i] + 1) begin
              m_act[i] = 0;
            end else begin
              c = m_k[i] - 1 - m_lat[i];
              if (c < 0) c = 0;
              if (c > m_n[i]) c = m_n[i];
              if (c > m_cnt[i]) begin
`ifdef HASH_LSB_FIRST_EN
                m_hash[i][m_cnt[i]*13 +: 13] = mem[m_cnt[i]];
`else
                m_hash[i] = (m_hash[i] << 13) | HW'(mem[m_cnt[i]]);
`endif
                m_cnt[i] = c;
              end
            end
          end else if (start_s[i]) begin
            m_act[i]  = 1;
            m_k[i]    = 1;
            m_n[i]    = (int'(degp_s[i]) > 624) ? 624 : int'(degp_s[i]);
            if (int'(degp_s[i]) > 624) m_derr[i] = 1;
            m_cnt[i]  = 0;
            m_hash[i] = '0;
          end
        end
      end
    end
  end

  // rp>0: re-pulse start (degp=3) in cycle rp; ab>=0: assert reset once address ab is on the bus
  task automatic run_load(input int i, input int dg, input int rp, input int ab,
                          output int lat, output int reads, output int last, output bit seen);
    @(posedge clk); #2;
    start_s[i] = 1'b1;
    degp_s[i]  = dg[10:0];
    @(posedge clk); #2;
    start_s[i] = 1'b0;
    lat = 0; reads = 0; last = -1; seen = 0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (rd_w[i]) begin
        reads++;
        last = int'(addr_w[i]);
      end
      if (done_w[i]) begin
        seen = 1;
      end else if (ab >= 0 && rd_w[i] && addr_w[i] == ab[10:0]) begin
        #3 rst_n = 1'b0;
        break;
      end else begin
        @(posedge clk); #2;
        if (rp > 0 && lat == rp) begin
          start_s[i] = 1'b1;
          degp_s[i]  = 11'd3;
        end else begin
          start_s[i] = 1'b0;
        end
      end
    end
    start_s[i] = 1'b0;
  endtask

  initial begin
    int lat, reads, last;
    bit seen;
    logic [63:0] exp_lo;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      degp_s[i]  = '0;
    end
    for (int a = 0; a < 2048; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy_w[0]), 64'd0);
    chk("reset_count", 64'(count_w[1]), 64'd0);

    for (int a = 0; a < 4; a++) mem[a] = 13'(a + 1);
    run_load(0, 4, 0, -1, lat, reads, last, seen);
    chk("n4_latency", 64'(lat), 64'd6);
    chk("n4_reads", 64'(reads), 64'd4);
    chk("n4_count", 64'(count_w[0]), 64'd4);
`ifdef HASH_LSB_FIRST_EN
    exp_lo = (64'd4 << 39) | (64'd3 << 26) | (64'd2 << 13) | 64'd1;
`else
    exp_lo = (64'd1 << 39) | (64'd2 << 26) | (64'd3 << 13) | 64'd4;
`endif
    chk("n4_hash_lo", 64'(hash_w[0][51:0]), exp_lo);
    chk("n4_hash_hi_zero", 64'(|hash_w[0][HW-1:52]), 64'd0);

    run_load(0, 0, 0, -1, lat, reads, last, seen);
    chk("n0_latency", 64'(lat), 64'd2);
    chk("n0_reads", 64'(reads), 64'd0);
    chk("n0_count", 64'(count_w[0]), 64'd0);
    chk("n0_hash", 64'(|hash_w[0]), 64'd0);

    for (int a = 0; a < 5; a++) mem[a] = 13'(100 + 3 * a);
    run_load(1, 5, 0, -1, lat, reads, last, seen);
    chk("lat3_latency", 64'(lat), 64'd9);
    chk("lat3_last_addr", 64'(last), 64'd4);
    chk("lat3_count", 64'(count_w[1]), 64'd5);
`ifdef HASH_LSB_FIRST_EN
    exp_lo = (64'd112 << 52) | (64'd109 << 39) | (64'd106 << 26) | (64'd103 << 13) | 64'd100;
`else
    exp_lo = (64'd100 << 52) | (64'd103 << 39) | (64'd106 << 26) | (64'd109 << 13) | 64'd112;
`endif
    chk("lat3_hash_lo", 64'(hash_w[1][64:0]), exp_lo);

    for (int a = 0; a < 20; a++) mem[a] = 13'(5 * a + 7);
    run_load(0, 20, 5, -1, lat, reads, last, seen);
    chk("restart_latency", 64'(lat), 64'd22);
    chk("restart_reads", 64'(reads), 64'd20);
    chk("restart_count", 64'(count_w[0]), 64'd20);

    for (int a = 0; a < 624; a++) mem[a] = 13'((a * 29 + 11) & 8191);
    run_load(0, 700, 0, -1, lat, reads, last, seen);
    chk("clamp_reads", 64'(reads), 64'd624);
    chk("clamp_last_addr", 64'(last), 64'd623);
    chk("clamp_latency", 64'(lat), 64'd626);
    chk("clamp_deg_err", 64'(derr_w[0]), 64'd1);
    run_load(0, 3, 0, -1, lat, reads, last, seen);
    chk("sticky_deg_err", 64'(derr_w[0]), 64'd1);
    chk("after_clamp_count", 64'(count_w[0]), 64'd3);

    for (int a = 0; a < 20; a++) mem[a] = 13'(a + 50);
    run_load(0, 20, 0, 10, lat, reads, last, seen);
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_reads", 64'(reads), 64'd11);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_count", 64'(count_w[0]), 64'd0);
    chk("abort_deg_err", 64'(derr_w[0]), 64'd0);
    chk("abort_hash", 64'(|hash_w[0]), 64'd0);
    run_load(0, 3, 0, -1, lat, reads, last, seen);
    chk("post_abort_latency", 64'(lat), 64'd5);
`ifdef HASH_LSB_FIRST_EN
    exp_lo = (64'd52 << 26) | (64'd51 << 13) | 64'd50;
`else
    exp_lo = (64'd50 << 26) | (64'd51 << 13) | 64'd52;
`endif
    chk("post_abort_hash", 64'(hash_w[0][38:0]), exp_lo);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_stream_loader.md
HASH_STREAM_LOADER -- requirements
Module: hash_stream_loader

Interface
REQ-001 SHALL have parameter COEF_W, default 13: bits per coefficient word.
REQ-002 SHALL have parameter MAX_DEG, default 624: buffer capacity in coefficients.
REQ-003 SHALL have parameter ADDR_W, default 11: memory address and degree width.
REQ-004 SHALL have parameter RD_LAT, default 1, legal range 1..4: memory read latency in cycles.
REQ-005 SHALL have ports: clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports: start  in  1  one-cycle request to load a new buffer.
REQ-008 SHALL have ports: degp  in  ADDR_W  number of coefficients to load; sampled when start is accepted.
REQ-009 SHALL have ports: mem_rd_en  out  1  memory read strobe.
REQ-010 SHALL have ports: mem_addr  out  ADDR_W  memory read address.
REQ-011 SHALL have ports: mem_rdata  in  COEF_W  read data, valid RD_LAT cycles after mem_rd_en.
REQ-012 SHALL have ports: busy  out  1  high while a load is in progress.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse when the buffer is complete.
REQ-014 SHALL have ports: hash_data  out  COEF_W*MAX_DEG  packed coefficient buffer.
REQ-015 SHALL have ports: count  out  ADDR_W  coefficients captured in the current or last load.
REQ-016 SHALL have ports: deg_err  out  1  sticky flag, set when degp exceeds MAX_DEG.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-018 In IDLE, start SHALL be accepted: latch n = min(degp, MAX_DEG), clear hash_data and count, go to ISSUE (or DRAIN if n=0).
REQ-019 start SHALL be ignored in ISSUE, DRAIN and DONE.
REQ-020 In ISSUE, mem_rd_en SHALL be 1 and mem_addr SHALL be i, for i = 0..n-1 on consecutive cycles, with no gaps.
REQ-021 After address n-1 is issued, the FSM SHALL go to DRAIN.
REQ-022 An RD_LAT-deep valid delay line SHALL tag returning data.
REQ-023 Each tagged mem_rdata word SHALL be captured into hash_data and SHALL increment count.
REQ-024 DRAIN SHALL exit to DONE once no tagged read is outstanding.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 Cycles from the start-accept edge to the done=1 cycle SHALL be exactly n+RD_LAT+1 (RD_LAT+1 for n=0).
REQ-027 Default packing SHALL be left-shift: next = {hash_data[..], mem_rdata}, truncated to COEF_W*MAX_DEG bits, so the last word sits at bits [COEF_W-1:0].
REQ-028 busy SHALL be 1 in ISSUE, DRAIN and DONE.
REQ-029 hash_data and count SHALL hold their values in IDLE until the next accepted start.
REQ-030 degp > MAX_DEG SHALL clamp n to MAX_DEG and set deg_err; deg_err SHALL clear only on reset.
REQ-031 mem_addr SHALL hold its last value when mem_rd_en=0.

Reset
REQ-032 While rst_n=0: state=IDLE; busy, done, mem_rd_en, deg_err = 0; mem_addr, count, hash_data and the delay line = 0.
REQ-033 Reset asserted mid-load SHALL abort the load with no done pulse; in-flight read data SHALL be discarded.

Configuration
REQ-034 Macro HASH_LSB_FIRST_EN SHALL select the packing mode at compile time.
REQ-035 With HASH_LSB_FIRST_EN defined, coefficient k SHALL be written in place at bits [k*COEF_W +: COEF_W], with no shifting; unused upper fields stay 0.
REQ-036 Without HASH_LSB_FIRST_EN, packing SHALL follow REQ-027.

Structure
REQ-037 The state enum, the RD_LAT bounds and the default COEF_W/MAX_DEG/ADDR_W values SHALL live in the shared package hash_pkg.
REQ-038 The read-valid delay line SHALL be the sub-module hash_rd_pipe (parameter RD_LAT), instantiated once.

Verification
REQ-039 Default mode, RD_LAT=1, degp=4, memory[0..3]=1,2,3,4: hash_data[51:0] = 1<<39 | 2<<26 | 3<<13 | 4; count=4; done exactly 6 cycles after start.
REQ-040 HASH_LSB_FIRST_EN, same stimulus: hash_data[51:0] = 4<<39 | 3<<26 | 2<<13 | 1; upper bits = 0.
REQ-041 degp=0: no mem_rd_en; done RD_LAT+1 cycles after start; hash_data=0; count=0.
REQ-042 degp=700, MAX_DEG=624: exactly 624 reads issued at addresses 0..623; deg_err=1 and stays set after the next degp=3 load.
REQ-043 start pulsed again while busy: ignored, with no address restart; rst_n driven low at read 10 of 20: all outputs reset, no done pulse, next start loads cleanly.
REQ-044 RD_LAT=3, degp=5: captured words match addresses 0..4 in order; done 9 cycles after start.
